noc_leaf_tx: RTL and testbench

Synchronous packet injector for the tree NoC, located between a clocked processing element (PE) and a leaf router's `child*_in` channel.
- Accepts destination and payload words from the PE through a valid/ready port.
- Buffers them in a small FIFO and stamps each packet with this node's source address.
- Drives each packet onto the router as the sender of a four-phase bundled-data (P4PhaseBD) channel.

It is the clocked transmit end of the same channel protocol that the router's receive side consumes.

---
 rtl/noc_leaf_tx.sv | 150 +++++++++++++++
 tb/tb_noc_leaf_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_leaf_tx.sv
// noc_leaf_tx: clocked PE-side packet injector driving a four-phase
// bundled-data request/acknowledge channel into a leaf router.
`timescale 1ns/1ps
module noc_leaf_tx #(
  parameter int WIDTH_packet = 14,
  parameter int WIDTH_dest = 3,
  parameter int WIDTH_addr = 3,
  parameter logic [WIDTH_addr-1:0] ADDR = 3'b000,
  parameter int DEPTH = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int WIDTH_payload = WIDTH_packet - WIDTH_dest - WIDTH_addr
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_dest-1:0]    in_dest,
  input  logic [WIDTH_payload-1:0] in_payload,
  output logic                     ch_req,
  input  logic                     ch_ack,
  output logic [WIDTH_packet-1:0]  ch_data,
  output logic                     busy,
  output logic [15:0]              sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_REL
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic                    ch_req_q, ch_req_d;
  logic [WIDTH_packet-1:0] ch_data_q, ch_data_d;
  logic                    busy_q, busy_d;
  logic [15:0]             sent_count_q, sent_count_d;
  logic [SW-1:0]           setup_cnt_q, setup_cnt_d;
  logic                    ack_meta_q, ack_meta_d;
  logic                    ack_s_q, ack_s_d;
  logic                    push, pop;

  logic [WIDTH_packet-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_dest, ADDR, in_payload};
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ch_req_d     = ch_req_q;
    ch_data_d    = ch_data_q;
    sent_count_d = sent_count_q;
    setup_cnt_d  = setup_cnt_q;
    ack_meta_d   = ch_ack;
    ack_s_d      = ack_meta_q;
    push         = in_valid && in_ready_q;
    pop          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          ch_data_d   = mem_q[rd_ptr_q];
          setup_cnt_d = '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        setup_cnt_d = setup_cnt_q + SW'(1);
        if (setup_cnt_d == SW'(SETUP_CYCLES)) begin
          ch_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s_q) begin
          ch_req_d = 1'b0;
          state_d  = S_REL;
        end
      end
      S_REL: begin
        if (!ack_s_q) begin
          sent_count_d = sent_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // ready follows next-cycle occupancy, so a full FIFO never accepts
    in_ready_d = (count_d != CW'(DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      ch_req_q     <= 1'b0;
      ch_data_q    <= '0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
      setup_cnt_q  <= '0;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      ch_req_q     <= ch_req_d;
      ch_data_q    <= ch_data_d;
      busy_q       <= busy_d;
      sent_count_q <= sent_count_d;
      setup_cnt_q  <= setup_cnt_d;
      ack_meta_q   <= ack_meta_d;
      ack_s_q      <= ack_s_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ch_req     = ch_req_q;
  assign ch_data    = ch_data_q;
  assign busy       = busy_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_noc_leaf_tx.sv
// Bench for noc_leaf_tx: directed scenarios plus randomized traffic
// against a queue-based model and a four-phase receiver model.
`timescale 1ns/1ps
module tb_noc_leaf_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_dest = '0;
  logic [7:0]  in_payload = '0;
  logic        ch_req;
  logic        ch_ack;
  logic [13:0] ch_data;
  logic        busy;
  logic [15:0] sent_count;

  int n_checks = 0;
  int n_fail = 0;
  int stab_err = 0;
  bit ack_stall = 1'b0;
  bit rand_dly = 1'b0;
  logic [15:0] sc_exp = '0;
  logic [13:0] exp_q[$];
  logic [13:0] rx_q[$];

  noc_leaf_tx dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_dest(in_dest),
    .in_payload(in_payload),
    .ch_req(ch_req),
    .ch_ack(ch_ack),
    .ch_data(ch_data),
    .busy(busy),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // four-phase receiver standing in for the router
  initial begin
    ch_ack = 1'b0;
    forever begin
      @(posedge ch_req);
      wait (!ack_stall);
      if (rand_dly) #($urandom_range(40)); else #1;
      if (ch_req !== 1'b1) continue;
      rx_q.push_back(ch_data);
      ch_ack = 1'b1;
      wait (ch_req === 1'b0);
      if (rand_dly) #($urandom_range(40)); else #1;
      ch_ack = 1'b0;
    end
  end

  always @(ch_data) begin
    if (reset === 1'b0 && (ch_req === 1'b1 || ch_ack === 1'b1))
      stab_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic [7:0] p,
                      output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_dest = d;
    in_payload = p;
    acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (acc) exp_q.push_back({d, 3'b000, p});
  endtask

  task automatic wait_sc(input logic [15:0] tgt, input int budget);
    int n = 0;
    while (sent_count !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("sent_count_reach", {16'd0, sent_count}, {16'd0, tgt});
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (ch_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_reach", {31'd0, ch_req}, 32'd1);
  endtask

  task automatic check_rx(input string tag);
    logic [13:0] got;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
      chk({tag, "_order"}, {18'd0, got}, {18'd0, exp_q.pop_front()});
    end
    rx_q.delete();
  endtask

  initial begin
    bit acc;
    logic [2:0] d;
    logic [7:0] p;
    logic [15:0] prev;
    int tries;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, ch_req}, 32'd0);
    chk("rst_data", {18'd0, ch_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sent", {16'd0, sent_count}, 32'd0);
    reset = 1'b0;

    // single packet and push-to-req latency
    push(3'b010, 8'hA5, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    chk("t1_data", {18'd0, ch_data}, 32'b010_000_10100101);
    chk("t1_req_low", {31'd0, ch_req}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("t1_req_high", {31'd0, ch_req}, 32'd1);
    sc_exp = sc_exp + 16'd1;
    wait_sc(sc_exp, 50);
    check_rx("t1");
    @(negedge clk);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // fill the FIFO behind a stalled handshake
    ack_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(3'(i + 1), 8'(8'h30 + i), acc);
      chk("t2_accept", {31'd0, acc}, (i < 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
    ack_stall = 1'b0;
    sc_exp = sc_exp + 16'd5;
    wait_sc(sc_exp, 200);
    check_rx("t2");
    chk("t2_ready_back", {31'd0, in_ready}, 32'd1);

    // push coinciding with pop at occupancy 2
    ack_stall = 1'b1;
    push(3'd5, 8'h11, acc);
    push(3'd6, 8'h22, acc);
    push(3'd7, 8'h33, acc);
    wait_req(20);
    chk("t4_occ_before", {29'd0, dut.count_q}, 32'd2);
    prev = sent_count;
    ack_stall = 1'b0;
    n = 0;
    while (sent_count === prev && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_dest = 3'd1;
    in_payload = 8'h44;
    acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (acc) exp_q.push_back({3'd1, 3'b000, 8'h44});
    chk("t4_accept", {31'd0, acc}, 32'd1);
    chk("t4_occ_after", {29'd0, dut.count_q}, 32'd2);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    sc_exp = sc_exp + 16'd4;
    wait_sc(sc_exp, 100);
    check_rx("t4");

    // random traffic with random receiver delays
    rand_dly = 1'b1;
    stab_err = 0;
    for (int i = 0; i < 50; i++) begin
      d = 3'($urandom);
      p = 8'($urandom);
      tries = 0;
      do begin
        push(d, p, acc);
        tries++;
      end while (!acc && tries < 100);
      if ($urandom_range(3) == 0) repeat ($urandom_range(6)) @(negedge clk);
    end
    sc_exp = sc_exp + 16'd50;
    wait_sc(sc_exp, 3000);
    check_rx("t3");
    chk("t3_stable", stab_err, 32'd0);
    rand_dly = 1'b0;

    // reset in the middle of a handshake
    ack_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(i), 8'(8'hC0 + i), acc);
    wait_req(20);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_req_drop", {31'd0, ch_req}, 32'd0);
    chk("t5_sent", {16'd0, sent_count}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    ack_stall = 1'b0;
    repeat (2) @(negedge clk);
    push(3'b110, 8'h5A, acc);
    sc_exp = 16'd1;
    wait_sc(sc_exp, 50);
    check_rx("t5");

    // sent_count wraps
    @(negedge clk);
    force dut.sent_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.sent_count_q;
    @(negedge clk);
    chk("t6_preload", {16'd0, sent_count}, 32'h0000FFFF);
    push(3'b001, 8'hEE, acc);
    sc_exp = 16'd0;
    wait_sc(sc_exp, 50);
    check_rx("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
